// File: rtl/mem_boot_loader.sv
// Streams a length-prefixed, checksummed image into memory, then releases the cpu from reset.
// Latency: each payload write is issued the cycle after its accept; done/error appear the cycle after the final accept.
// Backpressure: s_ready depends only on state (low during reset and in DONE/ERR); gaps in s_valid simply stall the loader.
module mem_boot_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        HDR  = 3'd0,
        DATA = 3'd1,
        CSUM = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] len_q;
    logic [DATA_W-1:0] sum_q;

    logic              accept;
    logic              hdr_ok;
    logic [ADDR_W:0]   wc_next;
    logic              last_payload;

    // Ready while a stream word is expected; held low while reset is asserted.
    assign s_ready = rst_n && ((state == HDR) || (state == DATA) || (state == CSUM));
    assign accept  = s_valid && s_ready;

    // Header must be a legal image length, compared over the full word width.
    assign hdr_ok  = (s_data != '0) && (s_data <= DATA_W'(DEPTH));

    // Count after this payload word; the image ends when it reaches the header length.
    assign wc_next      = word_count + {{ADDR_W{1'b0}}, 1'b1};
    assign last_payload = (len_q == {{(DATA_W-ADDR_W-1){1'b0}}, wc_next});

    // Boot FSM with registered memory write port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HDR;
            len_q      <= '0;
            sum_q      <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            cpu_rst_n  <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                HDR: begin
                    if (accept) begin
                        len_q <= s_data;
                        sum_q <= '0;
                        if (hdr_ok) begin
                            state <= DATA;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= word_count[ADDR_W-1:0];
                        mem_data   <= s_data;
                        sum_q      <= sum_q + s_data;
                        word_count <= wc_next;
                        if (last_payload) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        if (s_data == sum_q) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                DONE: state <= DONE;
                ERR:  state <= ERR;
                default: begin
                    state <= ERR;
                    error <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_boot_loader.sv
// Testbench for mem_boot_loader: directed and randomized image streams against a stream-level model.
// Latency: checks write pulses at negedge and status one cycle after the final accept.
// Backpressure: driver holds s_valid until s_ready, with bounded waits and optional gaps.
module tb_mem_boot_loader;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              cpu_rst_n;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    mem_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .cpu_rst_n  (cpu_rst_n),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Memory seen by the cpu, plus a log of every write pulse.
    logic [DATA_W-1:0] mem [DEPTH];
    int                wr_addr_q [$];
    logic [DATA_W-1:0] wr_data_q [$];
    int                wr_cyc_q  [$];

    always @(negedge clk) begin
        cyc++;
        if (mem_we === 1'b1) begin
            mem[mem_addr] = mem_data;
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(mem_data);
            wr_cyc_q.push_back(cyc);
        end
    end

    // Stimulus and reference expectations.
    logic [DATA_W-1:0] stim [$];
    int                exp_addr [$];
    logic [DATA_W-1:0] exp_data [$];
    logic              exp_done;
    logic              exp_err;
    int                exp_wc;
    int                exp_acc;

    // Status sampled just after the edge that took the final accepted word.
    logic last_done, last_err, last_crst, pre_done;

    // Stream-level model: header N, N payload words, checksum = sum mod 2^16.
    function automatic void model();
        int n;
        int sum;
        exp_addr.delete();
        exp_data.delete();
        n = int'(stim[0]);
        if (n < 1 || n > DEPTH) begin
            exp_err  = 1'b1;
            exp_done = 1'b0;
            exp_wc   = 0;
            exp_acc  = 1;
        end else begin
            sum = 0;
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(i);
                exp_data.push_back(stim[1+i]);
                sum = (sum + int'(stim[1+i])) % 65536;
            end
            exp_wc   = n;
            exp_acc  = n + 2;
            exp_done = (int'(stim[n+1]) == sum);
            exp_err  = !exp_done;
        end
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Offers each stim word in turn; stops if the loader stops taking words.
    task automatic drive_stream(input int gap_max, output int accepted);
        int t;
        int g;
        accepted = 0;
        foreach (stim[k]) begin
            g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            repeat (g) begin
                @(negedge clk);
                s_valid = 1'b0;
            end
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = stim[k];
            t = 0;
            while (s_ready !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (s_ready !== 1'b1) break;
            pre_done = done;
            @(posedge clk);
            accepted++;
            #1;
            last_done = done;
            last_err  = error;
            last_crst = cpu_rst_n;
        end
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h0003;
        repeat (3) @(negedge clk);
        vectors++;
        if ({s_ready, mem_we, cpu_rst_n, done, error} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got rdy/we/crst/done/err=%b required 00000",
                     {s_ready, mem_we, cpu_rst_n, done, error});
        end
        vectors++;
        if (word_count !== '0 || mem_addr !== '0 || mem_data !== '0) begin
            miscompares++;
            $display("FAIL reset_regs: got wc=%0d addr=%0d data=%h required 0/0/0",
                     word_count, mem_addr, mem_data);
        end
        s_valid = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        vectors++;
        if (s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got s_ready=%b required 1 after release", s_ready);
        end
    endtask

    task automatic test_normal();
        int base;
        int acc;
        apply_reset();
        stim = '{16'd3, 16'h1111, 16'h2222, 16'h0003, 16'h3336};
        model();
        base = wr_data_q.size();
        drive_stream(0, acc);
        vectors++;
        if (wr_data_q.size() - base != 3) begin
            miscompares++;
            $display("FAIL normal_nwr: got %0d writes required 3", wr_data_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (wr_addr_q[base+i] != exp_addr[i] || wr_data_q[base+i] !== exp_data[i]) begin
                    miscompares++;
                    $display("FAIL normal_wr%0d: got addr=%0d data=%h required addr=%0d data=%h",
                             i, wr_addr_q[base+i], wr_data_q[base+i], exp_addr[i], exp_data[i]);
                end
            end
            vectors++;
            if (wr_cyc_q[base+1] != wr_cyc_q[base] + 1 || wr_cyc_q[base+2] != wr_cyc_q[base+1] + 1) begin
                miscompares++;
                $display("FAIL normal_b2b: got write cycles %0d %0d %0d required consecutive",
                         wr_cyc_q[base], wr_cyc_q[base+1], wr_cyc_q[base+2]);
            end
        end
        vectors++;
        if (pre_done !== 1'b0 || last_done !== 1'b1 || last_crst !== 1'b1 || last_err !== 1'b0) begin
            miscompares++;
            $display("FAIL normal_release: got pre_done=%b done=%b crst=%b err=%b required 0/1/1/0",
                     pre_done, last_done, last_crst, last_err);
        end
        vectors++;
        if (word_count !== 7'd3 || s_ready !== 1'b0 || acc != exp_acc) begin
            miscompares++;
            $display("FAIL normal_final: got wc=%0d s_ready=%b acc=%0d required 3/0/%0d",
                     word_count, s_ready, acc, exp_acc);
        end
    endtask

    task automatic test_gapped();
        int base;
        int acc;
        apply_reset();
        mem[0] = '0; mem[1] = '0; mem[2] = '0;
        stim = '{16'd3, 16'h1111, 16'h2222, 16'h0003, 16'h3336};
        base = wr_data_q.size();
        foreach (stim[k]) begin
            repeat (2) begin
                @(negedge clk);
                s_valid = 1'b0;
            end
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = stim[k];
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        acc = wr_data_q.size() - base;
        vectors++;
        if (acc != 3) begin
            miscompares++;
            $display("FAIL gapped_nwr: got %0d writes required 3", acc);
        end
        vectors++;
        if (mem[0] !== 16'h1111 || mem[1] !== 16'h2222 || mem[2] !== 16'h0003) begin
            miscompares++;
            $display("FAIL gapped_mem: got %h %h %h required 1111 2222 0003", mem[0], mem[1], mem[2]);
        end
        vectors++;
        if (done !== 1'b1 || cpu_rst_n !== 1'b1 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL gapped_done: got done=%b crst=%b err=%b required 1/1/0", done, cpu_rst_n, error);
        end
    endtask

    task automatic test_bad_csum();
        int base;
        int acc;
        apply_reset();
        stim = '{16'd2, 16'hFFFF, 16'h0002, 16'h0000};
        model();
        base = wr_data_q.size();
        drive_stream(0, acc);
        vectors++;
        if (wr_data_q.size() - base != 2 || mem[0] !== 16'hFFFF || mem[1] !== 16'h0002) begin
            miscompares++;
            $display("FAIL badcsum_wr: got n=%0d mem0=%h mem1=%h required 2/ffff/0002",
                     wr_data_q.size() - base, mem[0], mem[1]);
        end
        vectors++;
        if (last_err !== 1'b1 || last_done !== 1'b0 || last_crst !== 1'b0 || exp_err !== 1'b1) begin
            miscompares++;
            $display("FAIL badcsum_status: got err=%b done=%b crst=%b required 1/0/0",
                     last_err, last_done, last_crst);
        end
    endtask

    task automatic test_bad_header();
        int base;
        int acc;
        logic [DATA_W-1:0] hdrs [2];
        hdrs[0] = 16'd0;
        hdrs[1] = 16'd65;
        for (int h = 0; h < 2; h++) begin
            apply_reset();
            stim = '{hdrs[h]};
            base = wr_data_q.size();
            drive_stream(0, acc);
            vectors++;
            if (last_err !== 1'b1 || last_done !== 1'b0 || last_crst !== 1'b0) begin
                miscompares++;
                $display("FAIL badhdr_%0d: got err=%b done=%b crst=%b required 1/0/0",
                         hdrs[h], last_err, last_done, last_crst);
            end
            vectors++;
            if (wr_data_q.size() != base || s_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL badhdr_%0d_nowr: got writes=%0d s_ready=%b required 0/0",
                         hdrs[h], wr_data_q.size() - base, s_ready);
            end
        end
    endtask

    task automatic test_full();
        int base;
        int acc;
        apply_reset();
        stim.delete();
        stim.push_back(16'd64);
        for (int i = 0; i < 64; i++) stim.push_back(DATA_W'(i));
        stim.push_back(16'h07E0);
        model();
        base = wr_data_q.size();
        drive_stream(0, acc);
        vectors++;
        if (wr_data_q.size() - base != 64) begin
            miscompares++;
            $display("FAIL full_nwr: got %0d writes required 64", wr_data_q.size() - base);
        end else begin
            vectors++;
            if (wr_addr_q[base+63] != 63 || wr_data_q[base+63] !== 16'd63) begin
                miscompares++;
                $display("FAIL full_last: got addr=%0d data=%h required 63/003f",
                         wr_addr_q[base+63], wr_data_q[base+63]);
            end
        end
        vectors++;
        if (word_count !== 7'd64 || done !== 1'b1 || cpu_rst_n !== 1'b1 || exp_done !== 1'b1) begin
            miscompares++;
            $display("FAIL full_done: got wc=%0d done=%b crst=%b required 64/1/1",
                     word_count, done, cpu_rst_n);
        end
    endtask

    task automatic test_reset_midload();
        int acc;
        logic [DATA_W-1:0] w [3];
        apply_reset();
        w[0] = 16'd5; w[1] = 16'h1234; w[2] = 16'h5678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = w[i];
            @(posedge clk);
        end
        #1;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        #1;
        vectors++;
        if (mem_we !== 1'b0 || word_count !== '0 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_clear: got we=%b wc=%0d s_ready=%b required 0/0/0",
                     mem_we, word_count, s_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stim = '{16'd1, 16'hABCD, 16'hABCD};
        drive_stream(0, acc);
        vectors++;
        if (mem[0] !== 16'hABCD || done !== 1'b1 || word_count !== 7'd1 || acc != 3) begin
            miscompares++;
            $display("FAIL midrst_reload: got mem0=%h done=%b wc=%0d acc=%0d required abcd/1/1/3",
                     mem[0], done, word_count, acc);
        end
    endtask

    task automatic test_random();
        int base;
        int acc;
        int n;
        int r;
        int sum;
        for (int it = 0; it < 10; it++) begin
            apply_reset();
            r = $urandom_range(0, 9);
            if (r == 0)      n = 0;
            else if (r == 1) n = 65 + $urandom_range(0, 60000);
            else             n = $urandom_range(1, DEPTH);
            stim.delete();
            stim.push_back(DATA_W'(n));
            if (n >= 1 && n <= DEPTH) begin
                sum = 0;
                for (int i = 0; i < n; i++) begin
                    stim.push_back(DATA_W'($urandom));
                    sum += int'(stim[i+1]);
                end
                if ($urandom_range(0, 3) == 0)
                    stim.push_back(DATA_W'(sum) ^ (16'h1 << $urandom_range(0, 15)));
                else
                    stim.push_back(DATA_W'(sum));
            end
            model();
            base = wr_data_q.size();
            drive_stream($urandom_range(0, 2), acc);
            vectors++;
            if (acc != exp_acc || wr_data_q.size() - base != exp_data.size()) begin
                miscompares++;
                $display("FAIL rand%0d_count: got acc=%0d writes=%0d required %0d/%0d",
                         it, acc, wr_data_q.size() - base, exp_acc, exp_data.size());
            end else begin
                for (int i = 0; i < exp_data.size(); i++) begin
                    vectors++;
                    if (wr_addr_q[base+i] != exp_addr[i] || wr_data_q[base+i] !== exp_data[i]) begin
                        miscompares++;
                        $display("FAIL rand%0d_wr%0d: got addr=%0d data=%h required addr=%0d data=%h",
                                 it, i, wr_addr_q[base+i], wr_data_q[base+i], exp_addr[i], exp_data[i]);
                    end
                end
            end
            vectors++;
            if (done !== exp_done || error !== exp_err || cpu_rst_n !== exp_done ||
                int'(word_count) != exp_wc || s_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL rand%0d_status: got done=%b err=%b crst=%b wc=%0d rdy=%b required %b/%b/%b/%0d/0",
                         it, done, error, cpu_rst_n, word_count, s_ready,
                         exp_done, exp_err, exp_done, exp_wc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_gapped();
        test_bad_csum();
        test_bad_header();
        test_full();
        test_reset_midload();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
